bob_retire: RTL and testbench

//  Retire-side controller downstream of the bob allocation/pointer block and the bob RAM.

---
 rtl/bob_retire_if.sv | 39 +++
 rtl/bob_retire.sv | 130 +++++++++++++
 tb/tb_bob_retire.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bob_retire_if.sv
// Bundle of the retire controller's connections to the pointer block, the
// execute completion port, the bob RAM read port and the commit/flush outputs.
//  slave  : the retire controller (bob_retire)
//  master : the surrounding logic (pointer block, execute, RAM, commit)
interface bob_retire_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
);
    logic                  except_in;
    logic                  alloc_en;
    logic [ADDR_WIDTH-1:0] alloc_addr;
    logic                  done_en;
    logic [ADDR_WIDTH-1:0] done_addr;
    logic                  done_mispred;
    logic                  has_retire;
    logic [ADDR_WIDTH-1:0] retire_addr;
    logic                  read_clkEn;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  do_retire;
    logic                  retire_valid;
    logic [DATA_WIDTH-1:0] retire_data;
    logic                  except_out;
    logic [DATA_WIDTH-1:0] except_data;

    modport slave (
        input  except_in, alloc_en, alloc_addr, done_en, done_addr, done_mispred,
        input  has_retire, retire_addr, read_data,
        output read_clkEn, read_addr, do_retire, retire_valid, retire_data,
        output except_out, except_data
    );

    modport master (
        output except_in, alloc_en, alloc_addr, done_en, done_addr, done_mispred,
        output has_retire, retire_addr, read_data,
        input  read_clkEn, read_addr, do_retire, retire_valid, retire_data,
        input  except_out, except_data
    );
endinterface

// File: rtl/bob_retire.sv
// Retire-side controller of the bob. Keeps per-entry done/mispredict bits,
// reads the head entry from the bob RAM, tells the pointer block when to
// retire the head, presents retired payloads to commit and raises a one-cycle
// flush when a mispredicted entry retires.
// Ports:
//  clk  - clock, all state on the rising edge
//  rst  - asynchronous active-low reset
//  bus  - bob_retire_if.slave: allocation/completion inputs, pointer block
//         head/count, RAM read port, do_retire, retire and flush outputs
module bob_retire #(
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63,
    parameter int DATA_WIDTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    bob_retire_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic [DEPTH-1:0] NO_ENTRIES = {DEPTH{1'b0}};

    state_t                state_r;
    logic [DEPTH-1:0]      done_r;
    logic [DEPTH-1:0]      misp_r;
    logic [ADDR_WIDTH-1:0] head_r;
    logic                  retire_valid_r;
    logic [DATA_WIDTH-1:0] retire_data_r;
    logic                  except_out_r;
    logic [DATA_WIDTH-1:0] except_data_r;

    logic                  do_retire_s;
    logic                  head_misp_s;
    logic [DEPTH-1:0]      head_mask_s;
    logic [DEPTH-1:0]      done_mask_s;
    logic [DEPTH-1:0]      alloc_mask_s;
    logic [DEPTH-1:0]      done_run_s;
    logic [DEPTH-1:0]      misp_run_s;

    // One-hot select of a single entry in the status vectors.
    function automatic logic [DEPTH-1:0] idx_mask(input logic [ADDR_WIDTH-1:0] idx);
        idx_mask = {{(DEPTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    // The RAM is read every cycle at the pointer block's next head, so one
    // cycle later read_data always holds entry head_r.
    assign bus.read_clkEn   = rst;
    assign bus.read_addr    = bus.retire_addr;
    assign bus.do_retire    = do_retire_s;
    assign bus.retire_valid = retire_valid_r;
    assign bus.retire_data  = retire_data_r;
    assign bus.except_out   = except_out_r;
    assign bus.except_data  = except_data_r;

    // Retire decision and next status bits while running. Priority for a
    // given entry, lowest to highest: retire clear, completion, allocation.
    always_comb begin
        do_retire_s  = (state_r == ST_RUN) && bus.has_retire && done_r[head_r] && !bus.except_in;
        head_misp_s  = misp_r[head_r];
        head_mask_s  = do_retire_s  ? idx_mask(head_r)         : NO_ENTRIES;
        done_mask_s  = bus.done_en  ? idx_mask(bus.done_addr)  : NO_ENTRIES;
        alloc_mask_s = bus.alloc_en ? idx_mask(bus.alloc_addr) : NO_ENTRIES;
        done_run_s   = ((done_r & ~head_mask_s) | done_mask_s) & ~alloc_mask_s;
        misp_run_s   = ((misp_r & ~head_mask_s & ~done_mask_s)
                       | (bus.done_mispred ? done_mask_s : NO_ENTRIES)) & ~alloc_mask_s;
    end

    // Retire FSM: status bits, head tracking and registered commit/flush outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_RUN;
            done_r         <= NO_ENTRIES;
            misp_r         <= NO_ENTRIES;
            head_r         <= {ADDR_WIDTH{1'b0}};
            retire_valid_r <= 1'b0;
            retire_data_r  <= {DATA_WIDTH{1'b0}};
            except_out_r   <= 1'b0;
            except_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            head_r         <= bus.retire_addr;
            retire_valid_r <= do_retire_s;
            if (do_retire_s) begin
                retire_data_r <= bus.read_data;
            end
            except_out_r <= 1'b0;
            if (bus.except_in) begin
                // External flush overrides everything and never raises except_out.
                done_r  <= NO_ENTRIES;
                misp_r  <= NO_ENTRIES;
                state_r <= ST_RECOVER;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        done_r <= done_run_s;
                        misp_r <= misp_run_s;
                        if (do_retire_s && head_misp_s) begin
                            // The mispredicted entry still retires; the flush
                            // carries the same payload as retire_data.
                            state_r       <= ST_FLUSH;
                            except_out_r  <= 1'b1;
                            except_data_r <= bus.read_data;
                        end
                    end
                    ST_FLUSH: begin
                        done_r  <= NO_ENTRIES;
                        misp_r  <= NO_ENTRIES;
                        state_r <= ST_RECOVER;
                    end
                    ST_RECOVER: begin
                        // Pointer block is reloading: drop any writes this cycle.
                        done_r  <= NO_ENTRIES;
                        misp_r  <= NO_ENTRIES;
                        state_r <= ST_RUN;
                    end
                    default: begin
                        done_r  <= NO_ENTRIES;
                        misp_r  <= NO_ENTRIES;
                        state_r <= ST_RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bob_retire.sv
module tb_bob_retire;
    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bob_retire_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    bob_retire #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // RAM contents: distinct, easy to hand-compute payload per entry.
    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        return {48'hD00D_0000_0000, 10'd0, a};
    endfunction

    function automatic int inc(input int a);
        return (a == DEPTH - 1) ? 0 : a + 1;
    endfunction

    // bob RAM with one cycle read latency
    always @(posedge clk) begin
        if (bus.read_clkEn) bus.read_data <= ram_val(bus.read_addr);
    end

    // Pointer block stand-in: head/count, next-head includes do_retire.
    int pb_head, pb_count;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_head  <= 0;
            pb_count <= 0;
        end else begin
            pb_head <= int'(bus.retire_addr);
            if (bus.except_out) pb_count <= 0;
            else pb_count <= pb_count + (bus.alloc_en ? 1 : 0) - (bus.do_retire ? 1 : 0);
        end
    end
    assign bus.has_retire  = (pb_count != 0);
    assign bus.retire_addr = bus.do_retire ? AW'(inc(pb_head)) : AW'(pb_head);

    // Behavioural model: mode 0=run 1=flush 2=recover
    bit              m_done [DEPTH];
    bit              m_misp [DEPTH];
    int              m_mode, m_head;
    bit              m_rv, m_eo;
    logic [DW-1:0]   m_rd, m_ed;
    logic            exp_do;
    int              exp_ra;
    assign exp_do = (m_mode == 0) && bus.has_retire && m_done[m_head] && !bus.except_in;
    assign exp_ra = exp_do ? inc(m_head) : m_head;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_done[i] <= 1'b0;
                m_misp[i] <= 1'b0;
            end
            m_mode <= 0; m_head <= 0; m_rv <= 1'b0; m_eo <= 1'b0;
            m_rd <= '0; m_ed <= '0;
        end else begin
            m_head <= exp_ra;
            m_rv   <= exp_do;
            if (exp_do) m_rd <= ram_val(AW'(m_head));
            m_eo <= 1'b0;
            if (bus.except_in || m_mode != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_done[i] <= 1'b0;
                    m_misp[i] <= 1'b0;
                end
                m_mode <= (bus.except_in || m_mode == 1) ? 2 : 0;
            end else begin
                if (exp_do) begin
                    m_done[m_head] <= 1'b0;
                    m_misp[m_head] <= 1'b0;
                    if (m_misp[m_head]) begin
                        m_mode <= 1;
                        m_eo   <= 1'b1;
                        m_ed   <= ram_val(AW'(m_head));
                    end
                end
                if (bus.done_en) begin
                    m_done[bus.done_addr] <= 1'b1;
                    m_misp[bus.done_addr] <= bus.done_mispred;
                end
                if (bus.alloc_en) begin
                    m_done[bus.alloc_addr] <= 1'b0;
                    m_misp[bus.alloc_addr] <= 1'b0;
                end
            end
        end
    end

    logic [DW-1:0] ret_q [$];
    int            n_retire = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] got(input int idx);
        if (idx < ret_q.size()) return ret_q[idx];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    // Per-cycle comparison against the model, taken at the falling edge.
    task automatic sample();
        if (!rst) begin
            chk("rst_do_retire",    64'(bus.do_retire),    64'd0);
            chk("rst_except_out",   64'(bus.except_out),   64'd0);
            chk("rst_retire_valid", 64'(bus.retire_valid), 64'd0);
            chk("rst_read_clken",   64'(bus.read_clkEn),   64'd0);
        end else begin
            chk("do_retire",    64'(bus.do_retire),    64'(exp_do));
            chk("read_clken",   64'(bus.read_clkEn),   64'd1);
            chk("read_addr",    64'(bus.read_addr),    64'(exp_ra));
            chk("retire_valid", 64'(bus.retire_valid), 64'(m_rv));
            if (m_rv) chk("retire_data", bus.retire_data, m_rd);
            chk("except_out",   64'(bus.except_out),   64'(m_eo));
            if (m_eo) chk("except_data", bus.except_data, m_ed);
            if (bus.retire_valid) ret_q.push_back(bus.retire_data);
            if (bus.do_retire) n_retire++;
        end
    endtask

    task automatic cyc(input bit a_en, input int a_addr, input bit d_en, input int d_addr,
                       input bit d_mp, input bit ex);
        @(posedge clk);
        #1;
        bus.alloc_en     = a_en;
        bus.alloc_addr   = AW'(a_addr);
        bus.done_en      = d_en;
        bus.done_addr    = AW'(d_addr);
        bus.done_mispred = d_mp;
        bus.except_in    = ex;
        @(negedge clk);
        sample();
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Allocate from..to-1 one per cycle, completing each one cycle later.
    task automatic drain_to(input int from, input int to);
        int nr;
        nr = n_retire;
        for (int i = from; i < to; i++) cyc(1'b1, i, (i > from), i - 1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, to - 1, 1'b0, 1'b0);
        repeat (3) idle();
        chk("drain_count", 64'(n_retire - nr), 64'(to - from));
    endtask

    int base, nr;

    initial begin
        bus.alloc_en = 1'b0; bus.alloc_addr = '0; bus.done_en = 1'b0; bus.done_addr = '0;
        bus.done_mispred = 1'b0; bus.except_in = 1'b0;
        #1 rst = 1'b0;

        // T1: reset held with random inputs
        repeat (5) begin
            @(posedge clk);
            #1;
            bus.alloc_en     = 1'($urandom);
            bus.alloc_addr   = AW'($urandom_range(0, 62));
            bus.done_en      = 1'($urandom);
            bus.done_addr    = AW'($urandom_range(0, 62));
            bus.done_mispred = 1'($urandom);
            bus.except_in    = 1'($urandom);
            @(negedge clk);
            sample();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.alloc_en = 1'b0; bus.done_en = 1'b0; bus.done_mispred = 1'b0; bus.except_in = 1'b0;
        @(negedge clk);
        sample();
        chk("t1_read_addr", 64'(bus.read_addr), 64'd0);

        // T2: in-order retirement after out-of-order completion
        for (int i = 0; i < 4; i++) cyc(1'b1, i, 1'b0, 0, 1'b0, 1'b0);
        base = ret_q.size();
        cyc(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("t2_no_early", 64'(bus.do_retire), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t2_consecutive", 64'(bus.do_retire), 64'd1);
        end
        idle();
        chk("t2_stop", 64'(bus.do_retire), 64'd0);
        idle();
        chk("t2_data0", got(base + 0), 64'hD00D_0000_0000_0000);
        chk("t2_data1", got(base + 1), 64'hD00D_0000_0000_0001);
        chk("t2_data2", got(base + 2), 64'hD00D_0000_0000_0002);
        chk("t2_data3", got(base + 3), 64'hD00D_0000_0000_0003);

        // T3: wrap 61, 62, 0
        drain_to(4, 61);
        cyc(1'b1, 61, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 62, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 0,  1'b0, 0, 1'b0, 1'b0);
        base = ret_q.size();
        cyc(1'b0, 0, 1'b1, 0,  1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 62, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 61, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t3_consecutive", 64'(bus.do_retire), 64'd1);
        end
        repeat (2) idle();
        chk("t3_data61", got(base + 0), 64'hD00D_0000_0000_003D);
        chk("t3_data62", got(base + 1), 64'hD00D_0000_0000_003E);
        chk("t3_data0",  got(base + 2), 64'hD00D_0000_0000_0000);

        // T4: mispredict on entry 5
        drain_to(1, 5);
        cyc(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 6, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 6, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
        idle();
        chk("t4_retire5", 64'(bus.do_retire), 64'd1);
        idle();
        chk("t4_except_out",  64'(bus.except_out), 64'd1);
        chk("t4_except_data", bus.except_data,     64'hD00D_0000_0000_0005);
        chk("t4_retire_data", bus.retire_data,     64'hD00D_0000_0000_0005);
        chk("t4_flush_hold",  64'(bus.do_retire),  64'd0);
        idle();
        chk("t4_recover_hold", 64'(bus.do_retire),  64'd0);
        chk("t4_except_once",  64'(bus.except_out), 64'd0);
        idle();
        chk("t4_no_retire6", 64'(bus.do_retire), 64'd0);

        // T5: alloc/done collision on entry 9
        cyc(1'b1, 6, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 8, 1'b0, 0, 1'b0, 1'b0);
        nr = n_retire;
        cyc(1'b1, 9, 1'b1, 9, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 6, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 7, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 8, 1'b0, 1'b0);
        repeat (4) idle();
        chk("t5_count", 64'(n_retire - nr), 64'd3);
        chk("t5_stuck9", 64'(bus.do_retire), 64'd0);
        cyc(1'b0, 0, 1'b1, 9, 1'b0, 1'b0);
        idle();
        chk("t5_retire9", 64'(bus.do_retire), 64'd1);
        repeat (2) idle();

        // T6: external flush in the middle of a retire stream
        for (int i = 10; i < 16; i++) cyc(1'b1, i, 1'b0, 0, 1'b0, 1'b0);
        nr = n_retire;
        cyc(1'b0, 0, 1'b1, 10, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 11, 1'b0, 1'b0);
        chk("t6_stream10", 64'(bus.do_retire), 64'd1);
        cyc(1'b0, 0, 1'b1, 12, 1'b0, 1'b0);
        chk("t6_stream11", 64'(bus.do_retire), 64'd1);
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        chk("t6_suppress", 64'(bus.do_retire), 64'd0);
        chk("t6_no_except_out", 64'(bus.except_out), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_done_cleared", 64'(bus.do_retire), 64'd0);
            chk("t6_no_except_out", 64'(bus.except_out), 64'd0);
        end
        chk("t6_count", 64'(n_retire - nr), 64'd2);
        for (int i = 12; i < 16; i++) cyc(1'b0, 0, 1'b1, i, 1'b0, 1'b0);
        repeat (3) idle();
        chk("t6_resume", 64'(n_retire - nr), 64'd6);

        // T7: reset in the middle of a flush
        cyc(1'b1, 16, 1'b0, 0,  1'b0, 1'b0);
        cyc(1'b0, 0,  1'b1, 16, 1'b1, 1'b0);
        idle();
        chk("t7_retire16", 64'(bus.do_retire), 64'd1);
        idle();
        chk("t7_flush", 64'(bus.except_out), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t7_abort_except_out", 64'(bus.except_out),   64'd0);
        chk("t7_abort_valid",      64'(bus.retire_valid), 64'd0);
        chk("t7_abort_read_en",    64'(bus.read_clkEn),   64'd0);
        repeat (2) idle();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        sample();
        cyc(1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
        idle();
        chk("t7_run_after_reset", 64'(bus.do_retire), 64'd1);
        repeat (2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
